rx_lane_sync_ctrl: RTL and testbench
====================================

# rx_lane_sync_ctrl

Receive-side lane synchronizer and deskew controller for the two-lane PHY. It sits between the lane deserializers and the byte un-striping block. It locks each lane on a run of COM symbols, measures and removes inter-lane skew, and only then forwards lane bytes with per-lane valids so that un-striping starts from a lane-0/lane-1 aligned pair. It drops to re-acquire on loss of sync and is observable through sync/active/skew status outputs.

## Interface
Parameters:
- COM, 8'hBC: alignment/idle symbol.
- SYNC_COUNT, 4: consecutive valid COM bytes needed to lock a lane (2..15).
- LOSS_COUNT, 4: consecutive invalid cycles that drop lane lock (1..15).
- MAX_SKEW, 3: largest correctable skew in clk_2f cycles (≤3).

Ports:
- clk_2f, input, 1: the only clock, byte rate per lane.
- reset, input, 1: asynchronous, active-high.
- lane_0_in / lane_1_in, input, 8: raw lane bytes.
- valid_in_0 / valid_in_1, input, 1: raw lane byte valid.
- lane_0 / lane_1, output, 8: aligned bytes to the un-striper.
- valid_0 / valid_1, output, 1: aligned byte valid.
- sync_0 / sync_1, output, 1: the lane is in SYNCED.
- active, output, 1: the controller is in ALIGNED.
- skew, output, 2: measured skew magnitude.
- skew_lane, output, 1: the lane that was delayed (0 or 1).
- skew_err, output, 1: sticky flag, set when skew exceeds MAX_SKEW.

## Operation
Per-lane lock FSM, one instance per lane, with counters good_cnt and bad_cnt of 4 bits each:
- IDLE: a valid COM byte moves the lane to LOCKING with good_cnt=1.
- LOCKING: a valid COM byte increments good_cnt. When good_cnt reaches SYNC_COUNT the lane moves to SYNCED and pulses locked for one cycle. A valid non-COM byte returns the lane to IDLE with good_cnt=0. Invalid cycles are ignored and hold state.
- SYNCED: a cycle with valid_in low increments bad_cnt. Any valid cycle clears bad_cnt. When bad_cnt reaches LOSS_COUNT the lane goes to IDLE and both counters clear.

Controller FSM:
- WAIT_SYNC: neither lane has pulsed locked since entry.
  - If both lanes pulse in the same cycle, skew=0 and the FSM goes to ALIGNED.
  - If one lane pulses, the FSM goes to MEASURE, clears skew_cnt, and records that lane as skew_lane.
- MEASURE: skew_cnt increments each cycle.
  - When the other lane pulses, skew latches skew_cnt+1 and the FSM goes to ALIGNED.
  - If skew_cnt+1 exceeds MAX_SKEW, or the first lane loses SYNCED, the FSM goes to SKEW_ERR. In the skew case skew_err is set.
- SKEW_ERR: lasts one cycle, forces both lane FSMs to IDLE, then the FSM goes to WAIT_SYNC.
- ALIGNED: active=1. If either lane leaves SYNCED, the FSM goes to WAIT_SYNC and active drops the next cycle.

Data path:
- The early lane (skew_lane) is delayed skew cycles through a depth-MAX_SKEW shift register. The other lane passes through undelayed.
- Both lanes then pass through one output register.
- In ALIGNED, valid_x = delayed valid_in_x AND (byte != COM). COM bytes are idles and are presented with valid low.
- Outside ALIGNED all outputs except status are 0.

Reset values:
- All outputs are 0.
- All FSMs are in IDLE / WAIT_SYNC.
- Shift registers and counters are cleared.
- skew_err clears only on reset.

## Timing
- Lane lock: a lane reaches SYNCED on the cycle after its SYNC_COUNT-th consecutive COM byte.
- Latency with DESKEW_EN, input to output:
  - late lane: 1 cycle;
  - early lane: 1+skew cycles.
- A byte pair launched skew cycles apart exits in the same cycle.
- Lock loss in the same cycle as the other lane's lock pulse: the loss has priority and the FSM goes to SKEW_ERR.
- Reset mid-operation: outputs go to 0 asynchronously and there is no partial-byte flush.

## Configuration
- RX_LANE_DESKEW_EN defined: the shift registers, skew measurement, MEASURE/SKEW_ERR states and skew_err are compiled in, as described above.
- RX_LANE_DESKEW_EN undefined:
  - WAIT_SYNC goes to ALIGNED when both sync_x are high.
  - Both lanes have a fixed 1-cycle latency.
  - skew, skew_lane and skew_err are tied to 0.

## Structure
- Shared package phy_pkg holds:
  - the lane FSM state encoding (IDLE, LOCKING, SYNCED);
  - the controller encoding (WAIT_SYNC, MEASURE, ALIGNED, SKEW_ERR);
  - the COM default;
  - the counter width constants.
- Sub-module lane_lock_fsm (per-lane lock FSM plus counters) is instantiated twice. The top level holds the controller FSM and the datapath.

## Test plan
- Clean lock: both lanes send 4×BC then 8'h11 on lane 0 and 8'h22 on lane 1, aligned → sync_x rise after the 4th BC, active=1, skew=0. Two cycles after entry the outputs are lane_0=11 and lane_1=22 with valid_0=valid_1=1.
- Skew 2: lane 1 lags lane 0 by 2 cycles → skew=2, skew_lane=0, and 11/22 appear on the outputs in the same cycle.
- Excess skew: lane 1 lags by 4 cycles → skew_err=1, both sync_x drop. Clean lock then succeeds with skew_err still 1.
- Broken lock run: BC,BC,8'h55,BC×4 → sync is reached only after the final 4 BCs.
- Loss: in ALIGNED, lane 0 valid held low for 4 cycles → sync_0=0, active=0, outputs 0. Re-lock recovers.
- Reset asserted mid-stream in ALIGNED → all outputs 0 immediately. After release, lock requires a full new BC run.

Source files
------------

// File: rtl/phy_pkg.sv
// ---------------------------------------------------------------------------
// phy_pkg
// Shared definitions for the two-lane PHY receive path.
//   - lane_state_t : per-lane lock FSM encoding (IDLE, LOCKING, SYNCED)
//   - ctrl_state_t : deskew controller encoding (WAIT_SYNC, MEASURE,
//                    ALIGNED, SKEW_ERR)
//   - COM_DEFAULT  : default alignment/idle symbol
//   - CNT_W        : width of the lane good/bad run counters
//   - SKEW_W       : width of the reported skew magnitude
//   - SKEW_CNT_W   : width of the skew measurement counter; one bit wider
//                    than SKEW_W so that "count + 1" can exceed the
//                    largest correctable skew without wrapping
// ---------------------------------------------------------------------------
package phy_pkg;

  localparam int         CNT_W       = 4;
  localparam int         SKEW_W      = 2;
  localparam int         SKEW_CNT_W  = 3;
  localparam logic [7:0] COM_DEFAULT = 8'hBC;

  typedef enum logic [1:0] {
    LANE_IDLE    = 2'd0,
    LANE_LOCKING = 2'd1,
    LANE_SYNCED  = 2'd2
  } lane_state_t;

  typedef enum logic [1:0] {
    CTRL_WAIT_SYNC = 2'd0,
    CTRL_MEASURE   = 2'd1,
    CTRL_ALIGNED   = 2'd2,
    CTRL_SKEW_ERR  = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/lane_lock_fsm.sv
// ---------------------------------------------------------------------------
// lane_lock_fsm
// Per-lane lock tracker. A lane locks after SYNC_COUNT consecutive valid
// COM bytes and drops lock after LOSS_COUNT consecutive invalid cycles.
//
// Ports:
//   clk_2f     in   byte-rate clock
//   reset      in   asynchronous, active-high
//   lane_in    in   raw lane byte
//   valid_in   in   raw lane byte valid
//   force_idle in   controller request to drop back to IDLE (wins over all)
//   locked     out  one-cycle pulse on the first cycle spent in SYNCED
//   synced     out  lane is currently in SYNCED
// ---------------------------------------------------------------------------
module lane_lock_fsm
  import phy_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEFAULT,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       clk_2f,
  input  logic       reset,
  input  logic [7:0] lane_in,
  input  logic       valid_in,
  input  logic       force_idle,
  output logic       locked,
  output logic       synced
);

  lane_state_t      r_state, w_stateNxt;
  logic [CNT_W-1:0] r_goodCnt, w_goodNxt;
  logic [CNT_W-1:0] r_badCnt, w_badNxt;
  logic             r_locked, w_lockedNxt;
  logic [CNT_W-1:0] w_goodInc, w_badInc;

  assign w_goodInc = r_goodCnt + CNT_W'(1);
  assign w_badInc  = r_badCnt + CNT_W'(1);

  // State and run counters. The locked pulse is registered together with
  // the SYNCED transition so it lines up with the first SYNCED cycle.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state   <= LANE_IDLE;
      r_goodCnt <= '0;
      r_badCnt  <= '0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_goodCnt <= w_goodNxt;
      r_badCnt  <= w_badNxt;
      r_locked  <= w_lockedNxt;
    end
  end

  // Next-state logic. While locking, invalid cycles are ignored entirely;
  // only a valid non-COM byte breaks the run. Once synced, any valid byte
  // (COM or data) proves the lane is alive and clears the loss counter.
  always_comb begin
    w_stateNxt  = r_state;
    w_goodNxt   = r_goodCnt;
    w_badNxt    = r_badCnt;
    w_lockedNxt = 1'b0;
    if (force_idle) begin
      w_stateNxt = LANE_IDLE;
      w_goodNxt  = '0;
      w_badNxt   = '0;
    end else begin
      case (r_state)
        LANE_IDLE: begin
          if (valid_in && (lane_in == COM)) begin
            w_stateNxt = LANE_LOCKING;
            w_goodNxt  = CNT_W'(1);
          end
        end
        LANE_LOCKING: begin
          if (valid_in) begin
            if (lane_in == COM) begin
              w_goodNxt = w_goodInc;
              if (w_goodInc == CNT_W'(SYNC_COUNT)) begin
                w_stateNxt  = LANE_SYNCED;
                w_lockedNxt = 1'b1;
              end
            end else begin
              w_stateNxt = LANE_IDLE;
              w_goodNxt  = '0;
            end
          end
        end
        LANE_SYNCED: begin
          if (valid_in) begin
            w_badNxt = '0;
          end else if (w_badInc == CNT_W'(LOSS_COUNT)) begin
            w_stateNxt = LANE_IDLE;
            w_goodNxt  = '0;
            w_badNxt   = '0;
          end else begin
            w_badNxt = w_badInc;
          end
        end
        default: begin
          w_stateNxt = LANE_IDLE;
          w_goodNxt  = '0;
          w_badNxt   = '0;
        end
      endcase
    end
  end

  assign locked = r_locked;
  assign synced = (r_state == LANE_SYNCED);

endmodule

// File: rtl/rx_lane_sync_ctrl.sv
// ---------------------------------------------------------------------------
// rx_lane_sync_ctrl
// Receive-side lane synchronizer and deskew controller for the two-lane PHY.
// Locks both lanes on COM runs, measures and removes inter-lane skew, and
// forwards aligned bytes (COM presented with valid low) only while ALIGNED.
//
// Build option: define RX_LANE_DESKEW_EN to compile in the skew measurement,
// the early-lane delay lines, the MEASURE/SKEW_ERR states and skew_err.
// Without it both lanes have a fixed 1-cycle latency and the skew status
// outputs are tied to 0.
//
// Ports:
//   clk_2f                 in   byte-rate clock
//   reset                  in   asynchronous, active-high
//   lane_0_in / lane_1_in  in   raw lane bytes
//   valid_in_0/valid_in_1  in   raw lane byte valids
//   lane_0 / lane_1        out  aligned bytes to the un-striper
//   valid_0 / valid_1      out  aligned byte valids (low for COM)
//   sync_0 / sync_1        out  lane is in SYNCED
//   active                 out  controller is in ALIGNED
//   skew                   out  measured skew magnitude
//   skew_lane              out  lane that was delayed (the early one)
//   skew_err               out  sticky: skew exceeded MAX_SKEW
// ---------------------------------------------------------------------------
module rx_lane_sync_ctrl
  import phy_pkg::*;
#(
  parameter logic [7:0] COM        = COM_DEFAULT,
  parameter int         SYNC_COUNT = 4,
  parameter int         LOSS_COUNT = 4,
  parameter int         MAX_SKEW   = 3
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [7:0]        lane_0_in,
  input  logic [7:0]        lane_1_in,
  input  logic              valid_in_0,
  input  logic              valid_in_1,
  output logic [7:0]        lane_0,
  output logic [7:0]        lane_1,
  output logic              valid_0,
  output logic              valid_1,
  output logic              sync_0,
  output logic              sync_1,
  output logic              active,
  output logic [SKEW_W-1:0] skew,
  output logic              skew_lane,
  output logic              skew_err
);

  ctrl_state_t r_state, w_stateNxt;
  logic        w_locked0, w_locked1;
  logic        w_sync0, w_sync1;
  logic        w_forceIdle;
  logic [7:0]  w_dlyByte0, w_dlyByte1;
  logic        w_dlyVld0, w_dlyVld1;
  logic [7:0]  r_lane0, r_lane1;
  logic        r_valid0, r_valid1;

  lane_lock_fsm #(
    .COM        (COM),
    .SYNC_COUNT (SYNC_COUNT),
    .LOSS_COUNT (LOSS_COUNT)
  ) u_lane0 (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .lane_in    (lane_0_in),
    .valid_in   (valid_in_0),
    .force_idle (w_forceIdle),
    .locked     (w_locked0),
    .synced     (w_sync0)
  );

  lane_lock_fsm #(
    .COM        (COM),
    .SYNC_COUNT (SYNC_COUNT),
    .LOSS_COUNT (LOSS_COUNT)
  ) u_lane1 (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .lane_in    (lane_1_in),
    .valid_in   (valid_in_1),
    .force_idle (w_forceIdle),
    .locked     (w_locked1),
    .synced     (w_sync1)
  );

`ifdef RX_LANE_DESKEW_EN

  logic [SKEW_CNT_W-1:0]     r_skewCnt, w_skewCntNxt, w_skewCntInc;
  logic [SKEW_W-1:0]         r_skew, w_skewNxt;
  logic                      r_skewLane, w_skewLaneNxt;
  logic                      r_skewErr, w_skewErrNxt;
  logic                      w_firstSync, w_otherLocked;
  logic [MAX_SKEW-1:0][7:0]  r_srByte0, r_srByte1;
  logic [MAX_SKEW-1:0]       r_srVld0, r_srVld1;

  assign w_skewCntInc  = r_skewCnt + SKEW_CNT_W'(1);
  assign w_firstSync   = r_skewLane ? w_sync1 : w_sync0;
  assign w_otherLocked = r_skewLane ? w_locked0 : w_locked1;
  assign w_forceIdle   = (r_state == CTRL_SKEW_ERR);

  // Controller state plus skew bookkeeping. skew/skew_lane only change on
  // entry to ALIGNED or MEASURE, so the delay tap stays stable while aligned.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state    <= CTRL_WAIT_SYNC;
      r_skewCnt  <= '0;
      r_skew     <= '0;
      r_skewLane <= 1'b0;
      r_skewErr  <= 1'b0;
    end else begin
      r_state    <= w_stateNxt;
      r_skewCnt  <= w_skewCntNxt;
      r_skew     <= w_skewNxt;
      r_skewLane <= w_skewLaneNxt;
      r_skewErr  <= w_skewErrNxt;
    end
  end

  // Controller next state. In MEASURE the first lane losing lock beats an
  // overflowing count, which in turn beats the other lane's lock pulse, so
  // a simultaneous loss and pulse always lands in SKEW_ERR.
  always_comb begin
    w_stateNxt    = r_state;
    w_skewCntNxt  = r_skewCnt;
    w_skewNxt     = r_skew;
    w_skewLaneNxt = r_skewLane;
    w_skewErrNxt  = r_skewErr;
    case (r_state)
      CTRL_WAIT_SYNC: begin
        if (w_locked0 && w_locked1) begin
          w_stateNxt    = CTRL_ALIGNED;
          w_skewNxt     = '0;
          w_skewLaneNxt = 1'b0;
        end else if (w_locked0) begin
          w_stateNxt    = CTRL_MEASURE;
          w_skewCntNxt  = '0;
          w_skewLaneNxt = 1'b0;
        end else if (w_locked1) begin
          w_stateNxt    = CTRL_MEASURE;
          w_skewCntNxt  = '0;
          w_skewLaneNxt = 1'b1;
        end
      end
      CTRL_MEASURE: begin
        if (!w_firstSync) begin
          w_stateNxt = CTRL_SKEW_ERR;
        end else if (w_skewCntInc > SKEW_CNT_W'(MAX_SKEW)) begin
          w_stateNxt   = CTRL_SKEW_ERR;
          w_skewErrNxt = 1'b1;
        end else if (w_otherLocked) begin
          w_stateNxt = CTRL_ALIGNED;
          w_skewNxt  = w_skewCntInc[SKEW_W-1:0];
        end else begin
          w_skewCntNxt = w_skewCntInc;
        end
      end
      CTRL_SKEW_ERR: begin
        w_stateNxt = CTRL_WAIT_SYNC;
      end
      CTRL_ALIGNED: begin
        if (!(w_sync0 && w_sync1)) begin
          w_stateNxt = CTRL_WAIT_SYNC;
        end
      end
      default: begin
        w_stateNxt = CTRL_WAIT_SYNC;
      end
    endcase
  end

  // Free-running delay lines on both lanes; which one is tapped is decided
  // by the skew measurement.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_srByte0 <= '0;
      r_srByte1 <= '0;
      r_srVld0  <= '0;
      r_srVld1  <= '0;
    end else begin
      r_srByte0[0] <= lane_0_in;
      r_srByte1[0] <= lane_1_in;
      r_srVld0[0]  <= valid_in_0;
      r_srVld1[0]  <= valid_in_1;
      for (int i = 1; i < MAX_SKEW; i++) begin
        r_srByte0[i] <= r_srByte0[i-1];
        r_srByte1[i] <= r_srByte1[i-1];
        r_srVld0[i]  <= r_srVld0[i-1];
        r_srVld1[i]  <= r_srVld1[i-1];
      end
    end
  end

  // Tap selection. The next-cycle skew values are used so the very first
  // byte pair loaded on entry to ALIGNED is already deskewed.
  always_comb begin
    w_dlyByte0 = lane_0_in;
    w_dlyByte1 = lane_1_in;
    w_dlyVld0  = valid_in_0;
    w_dlyVld1  = valid_in_1;
    for (int k = 1; k <= MAX_SKEW; k++) begin
      if (w_skewNxt == SKEW_W'(k)) begin
        if (w_skewLaneNxt) begin
          w_dlyByte1 = r_srByte1[k-1];
          w_dlyVld1  = r_srVld1[k-1];
        end else begin
          w_dlyByte0 = r_srByte0[k-1];
          w_dlyVld0  = r_srVld0[k-1];
        end
      end
    end
  end

  assign skew      = r_skew;
  assign skew_lane = r_skewLane;
  assign skew_err  = r_skewErr;

`else

  logic w_unused;

  assign w_forceIdle = 1'b0;
  assign w_dlyByte0  = lane_0_in;
  assign w_dlyByte1  = lane_1_in;
  assign w_dlyVld0   = valid_in_0;
  assign w_dlyVld1   = valid_in_1;
  assign skew        = '0;
  assign skew_lane   = 1'b0;
  assign skew_err    = 1'b0;
  assign w_unused    = ^{w_locked0, w_locked1, 2'(MAX_SKEW)};

  // Controller state register for the non-deskew build.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_state <= CTRL_WAIT_SYNC;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  // Without deskew, alignment is simply "both lanes synced".
  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      CTRL_WAIT_SYNC: begin
        if (w_sync0 && w_sync1) begin
          w_stateNxt = CTRL_ALIGNED;
        end
      end
      CTRL_ALIGNED: begin
        if (!(w_sync0 && w_sync1)) begin
          w_stateNxt = CTRL_WAIT_SYNC;
        end
      end
      default: begin
        w_stateNxt = CTRL_WAIT_SYNC;
      end
    endcase
  end

`endif

  // Output register. It is loaded against the next controller state, so the
  // data outputs are non-zero exactly while the controller is ALIGNED and
  // fall to zero on the same edge that drops active.
  always_ff @(posedge clk_2f or posedge reset) begin
    if (reset) begin
      r_lane0  <= '0;
      r_lane1  <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end else if (w_stateNxt == CTRL_ALIGNED) begin
      r_lane0  <= w_dlyByte0;
      r_lane1  <= w_dlyByte1;
      r_valid0 <= w_dlyVld0 && (w_dlyByte0 != COM);
      r_valid1 <= w_dlyVld1 && (w_dlyByte1 != COM);
    end else begin
      r_lane0  <= '0;
      r_lane1  <= '0;
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
    end
  end

  assign lane_0  = r_lane0;
  assign lane_1  = r_lane1;
  assign valid_0 = r_valid0;
  assign valid_1 = r_valid1;
  assign sync_0  = w_sync0;
  assign sync_1  = w_sync1;
  assign active  = (r_state == CTRL_ALIGNED);

endmodule

// File: tb/tb_rx_lane_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_lane_sync_ctrl
// Directed bench for rx_lane_sync_ctrl. Each applyStimulus call drives one
// byte per lane, waits for the sampling edge and settles 1 ns after it.
// Skew-specific scenarios are built only when RX_LANE_DESKEW_EN is defined.
// ---------------------------------------------------------------------------
module tb_rx_lane_sync_ctrl;

  logic       clk_2f;
  logic       reset;
  logic [7:0] lane_0_in, lane_1_in;
  logic       valid_in_0, valid_in_1;
  logic [7:0] lane_0, lane_1;
  logic       valid_0, valid_1;
  logic       sync_0, sync_1;
  logic       active;
  logic [1:0] skew;
  logic       skew_lane;
  logic       skew_err;

  int checkCount = 0;
  int errorCount = 0;

  rx_lane_sync_ctrl dut (
    .clk_2f     (clk_2f),
    .reset      (reset),
    .lane_0_in  (lane_0_in),
    .lane_1_in  (lane_1_in),
    .valid_in_0 (valid_in_0),
    .valid_in_1 (valid_in_1),
    .lane_0     (lane_0),
    .lane_1     (lane_1),
    .valid_0    (valid_0),
    .valid_1    (valid_1),
    .sync_0     (sync_0),
    .sync_1     (sync_1),
    .active     (active),
    .skew       (skew),
    .skew_lane  (skew_lane),
    .skew_err   (skew_err)
  );

  // Free-running byte clock, 10 ns period.
  initial clk_2f = 1'b0;
  always #5 clk_2f = ~clk_2f;

  // Drive one byte per lane, then settle just after the sampling edge.
  task automatic applyStimulus(input logic [7:0] l0, input logic v0,
                               input logic [7:0] l1, input logic v1);
    lane_0_in  = l0;
    valid_in_0 = v0;
    lane_1_in  = l1;
    valid_in_1 = v1;
    @(posedge clk_2f);
    #1;
  endtask

  // One comparison: count it, and on mismatch count and report it.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      errorCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Synchronous-looking reset pulse covering one full clock edge.
  task automatic doReset();
    lane_0_in  = 8'h00;
    lane_1_in  = 8'h00;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    reset      = 1'b1;
    @(posedge clk_2f);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    lane_0_in  = 8'h00;
    lane_1_in  = 8'h00;
    valid_in_0 = 1'b0;
    valid_in_1 = 1'b0;
    reset      = 1'b1;
    #1;

    // Reset state
    checkOutput("rst_lane_0",   lane_0,   8'h00);
    checkOutput("rst_valid_0",  valid_0,  8'h00);
    checkOutput("rst_lane_1",   lane_1,   8'h00);
    checkOutput("rst_valid_1",  valid_1,  8'h00);
    checkOutput("rst_sync_0",   sync_0,   8'h00);
    checkOutput("rst_sync_1",   sync_1,   8'h00);
    checkOutput("rst_active",   active,   8'h00);
    checkOutput("rst_skew",     skew,     8'h00);
    checkOutput("rst_skew_err", skew_err, 8'h00);
    #11;
    reset = 1'b0;

    // Clean lock: 4x BC on both lanes, then 11/22
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("clean_sync_0_after3", sync_0, 8'h00);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("clean_sync_0", sync_0, 8'h01);
    checkOutput("clean_sync_1", sync_1, 8'h01);
    checkOutput("clean_active_pre", active, 8'h00);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("clean_active", active, 8'h01);
    checkOutput("clean_skew", skew, 8'h00);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("clean_lane_0", lane_0, 8'h11);
    checkOutput("clean_lane_1", lane_1, 8'h22);
    checkOutput("clean_valid_0", valid_0, 8'h01);
    checkOutput("clean_valid_1", valid_1, 8'h01);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("idle_lane_0", lane_0, 8'hBC);
    checkOutput("idle_valid_0", valid_0, 8'h00);
    checkOutput("idle_valid_1", valid_1, 8'h00);

    // Reset mid-stream while aligned
    applyStimulus(8'h33, 1, 8'h44, 1);
    checkOutput("pre_rst_lane_0", lane_0, 8'h33);
    checkOutput("pre_rst_lane_1", lane_1, 8'h44);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_lane_0", lane_0, 8'h00);
    checkOutput("midrst_valid_1", valid_1, 8'h00);
    checkOutput("midrst_active", active, 8'h00);
    checkOutput("midrst_sync_0", sync_0, 8'h00);
    @(negedge clk_2f);
    reset = 1'b0;
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("relock_sync_0_after3", sync_0, 8'h00);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("relock_sync_0", sync_0, 8'h01);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("relock_active", active, 8'h01);

    // Loss of sync on lane 0: valid held low for 4 cycles
    applyStimulus(8'h00, 0, 8'h22, 1);
    applyStimulus(8'h00, 0, 8'h22, 1);
    applyStimulus(8'h00, 0, 8'h22, 1);
    checkOutput("loss_sync_0_after3", sync_0, 8'h01);
    applyStimulus(8'h00, 0, 8'h22, 1);
    checkOutput("loss_sync_0", sync_0, 8'h00);
    checkOutput("loss_valid_0", valid_0, 8'h00);
    checkOutput("loss_active_hold", active, 8'h01);
    applyStimulus(8'hBC, 1, 8'h22, 1);
    checkOutput("loss_active", active, 8'h00);
    checkOutput("loss_lane_1", lane_1, 8'h00);
    checkOutput("loss_valid_1", valid_1, 8'h00);
`ifndef RX_LANE_DESKEW_EN
    applyStimulus(8'hBC, 1, 8'h22, 1);
    applyStimulus(8'hBC, 1, 8'h22, 1);
    applyStimulus(8'hBC, 1, 8'h22, 1);
    checkOutput("recover_sync_0", sync_0, 8'h01);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("recover_active", active, 8'h01);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("recover_lane_0", lane_0, 8'h11);
    checkOutput("recover_valid_0", valid_0, 8'h01);
`endif

    // Broken lock run: BC,BC,55 then BC x4
    doReset();
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'h55, 1, 8'h55, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("broken_sync_0_after3", sync_0, 8'h00);
    checkOutput("broken_sync_1_after3", sync_1, 8'h00);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("broken_sync_0", sync_0, 8'h01);
    checkOutput("broken_sync_1", sync_1, 8'h01);

`ifdef RX_LANE_DESKEW_EN
    // Skew 2: lane 1 lags lane 0 by two cycles
    doReset();
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("skew2_sync_0", sync_0, 8'h01);
    checkOutput("skew2_sync_1_pre", sync_1, 8'h00);
    applyStimulus(8'h11, 1, 8'hBC, 1);
    applyStimulus(8'h01, 1, 8'hBC, 1);
    checkOutput("skew2_sync_1", sync_1, 8'h01);
    checkOutput("skew2_active_pre", active, 8'h00);
    applyStimulus(8'h01, 1, 8'h22, 1);
    checkOutput("skew2_active", active, 8'h01);
    checkOutput("skew2_skew", skew, 8'h02);
    checkOutput("skew2_skew_lane", skew_lane, 8'h00);
    checkOutput("skew2_lane_0", lane_0, 8'h11);
    checkOutput("skew2_lane_1", lane_1, 8'h22);
    checkOutput("skew2_valid_0", valid_0, 8'h01);
    checkOutput("skew2_valid_1", valid_1, 8'h01);
    applyStimulus(8'h01, 1, 8'h02, 1);
    checkOutput("skew2_next_lane_0", lane_0, 8'h01);
    checkOutput("skew2_next_lane_1", lane_1, 8'h02);

    // Excess skew: lane 1 lags lane 0 by four cycles
    doReset();
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'hBC, 1, 8'h00, 0);
    applyStimulus(8'h11, 1, 8'hBC, 1);
    applyStimulus(8'h11, 1, 8'hBC, 1);
    applyStimulus(8'h11, 1, 8'hBC, 1);
    applyStimulus(8'h11, 1, 8'hBC, 1);
    checkOutput("xskew_sync_1", sync_1, 8'h01);
    checkOutput("xskew_err_pre", skew_err, 8'h00);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("xskew_err", skew_err, 8'h01);
    checkOutput("xskew_active", active, 8'h00);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("xskew_sync_0_drop", sync_0, 8'h00);
    checkOutput("xskew_sync_1_drop", sync_1, 8'h00);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    applyStimulus(8'hBC, 1, 8'hBC, 1);
    checkOutput("xskew_relock_sync_0", sync_0, 8'h01);
    checkOutput("xskew_relock_sync_1", sync_1, 8'h01);
    applyStimulus(8'h11, 1, 8'h22, 1);
    checkOutput("xskew_relock_active", active, 8'h01);
    checkOutput("xskew_relock_skew", skew, 8'h00);
    checkOutput("xskew_err_sticky", skew_err, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
